led_pattern_arbiter: RTL
========================

Name: led_pattern_arbiter

Overview:
- Shares the single on-board user LED (WF_LED) between N_REQ requesters, each of which supplies an 8-bit blink pattern.
- A free-running tick prescaler paces playback. A round-robin arbiter grants the LED for a bounded slot, then inserts a dark gap before re-arbitrating.
- Sits between status/debug sources and the board LED pin, and replaces ad-hoc free-running blinkers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TICK_DIV, 800000, clk cycles per pattern bit (50 ms at 16 MHz); must be >= 2.
- SLOT_REPS, 4, full 8-bit pattern passes per grant (>= 1).
- GAP_TICKS, 4, ticks of forced LED-off after each slot (>= 1).
- IDLE_TOGGLE, 10, ticks per idle heartbeat toggle (used only with the optional feature).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous reset, active-high.
- req  input  N_REQ  per-requester request level; held high while the requester wants the LED.
- pattern  input  8*N_REQ  pattern for requester i at [8i+7:8i]; bit 7 is shown first.
- grant  output  N_REQ  one-hot owner of the LED; all zero when no requester owns it.
- busy  output  1  high in PLAY or GAP.
- done  output  1  one-cycle pulse when a slot's gap ends.
- WF_LED  output  1  user LED drive, registered.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values:
  - grant=0, busy=0, done=0, WF_LED=0.
  - state=IDLE, tick counter=0.
  - Round-robin pointer=0, so requester 0 has top priority first.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is asserted combinationally while counter==TICK_DIV-1.
  - The counter runs in every state.
  - All state, LED and grant changes occur only on clk edges where tick=1. Exception: done clears after one cycle.
- IDLE:
  - On a tick with |req, pick the first set req[i] searching from the pointer upward, wrapping modulo N_REQ.
  - Same edge: grant<=onehot(i), pointer<=(i+1)%N_REQ, load shift register with pattern[i], WF_LED<=pattern[i][7], bitcnt=0, rep=0, busy<=1, state=PLAY.
  - On a tick with req==0: stay in IDLE; WF_LED per the optional feature.
- PLAY, evaluated each tick:
  - bitcnt<7: WF_LED<=next pattern bit (MSB-first), bitcnt++.
  - bitcnt==7, rep<SLOT_REPS-1, and req[granted] still high: re-sample pattern[granted] (live update allowed at pass boundaries only), WF_LED<=its bit 7, bitcnt=0, rep++.
  - bitcnt==7 otherwise (reps exhausted or req dropped): WF_LED<=0, gapcnt=0, state=GAP. grant stays asserted.
  - Dropping req mid-pass never truncates the pass; the current 8 bits always complete.
- GAP, evaluated each tick:
  - WF_LED stays 0 and gapcnt increments.
  - On the tick where gapcnt==GAP_TICKS-1: grant<=0, busy<=0, done<=1 for one cycle, state=IDLE.
- Timing consequences:
  - New requests are never granted on the same tick a slot ends. The earliest re-grant is the next tick.
  - A full slot occupies 8*SLOT_REPS+GAP_TICKS ticks from grant edge to done edge.
- Changes to req or pattern between ticks have no effect. Only values present on tick edges matter.
- rst asserted in any state returns everything to the reset values on that edge, including mid-PLAY and mid-GAP. No done pulse is generated on reset.
- Round-robin fairness: with all requests held high, grants rotate 0,1,2,...,N_REQ-1,0.

Optional Feature:
- Macro: LED_IDLE_HEARTBEAT_EN.
- Defined: in IDLE, a heartbeat counter counts ticks. WF_LED toggles every IDLE_TOGGLE ticks while no requester is granted. The heartbeat counter and WF_LED reset to 0 on each entry to IDLE.
- Undefined: WF_LED is held 0 in IDLE and the heartbeat logic is absent.

Test Plan:
Bench parameters unless noted: TICK_DIV=4, SLOT_REPS=2, GAP_TICKS=2, N_REQ=4, macro undefined.
1. Reset, then req=0 for 100 cycles -> WF_LED=0, grant=0, busy=0, done never pulses; tick every 4th cycle.
2. req=4'b0010, pattern1=8'hA5 -> grant=4'b0010 on the first tick. WF_LED shows 1,0,1,0,0,1,0,1 twice, one bit per 4 cycles, then 0 for 2 ticks. done pulses once after 18 ticks; grant=0.
3. req=4'b1111 held, distinct patterns -> grants in order 0001,0010,0100,1000,0001, each slot 18 ticks with no overlap.
4. Requester 2 drops req at bit 3 of pass 0 -> pass 0 completes its 8 bits, GAP follows without pass 1, done pulses after 10 ticks.
5. rst asserted mid-PLAY at bit 5 -> next cycle grant=0, WF_LED=0, busy=0, no done. After release, requester 0 wins despite the prior pointer.
6. LED_IDLE_HEARTBEAT_EN defined, IDLE_TOGGLE=3, req=0 -> WF_LED toggles every 12 cycles. A request arrives -> heartbeat is replaced by the pattern on the grant tick; after done, the heartbeat restarts from 0.

Source files
------------

// File: rtl/led_pattern_arbiter.sv
// rtl/led_pattern_arbiter.sv - round-robin arbiter sharing one LED between N_REQ blink-pattern requesters (optional idle heartbeat: LED_IDLE_HEARTBEAT_EN)
module led_pattern_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TICK_DIV    = 800000,
    parameter int SLOT_REPS   = 4,
    parameter int GAP_TICKS   = 4,
    parameter int IDLE_TOGGLE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   pattern,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 done,
    output logic                 WF_LED
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(N_REQ);
    localparam int SW = PW + 1;
    localparam int RW = $clog2(SLOT_REPS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(SLOT_REPS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);
    localparam logic [SW-1:0] N_WRAP    = SW'(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               led_q, led_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [RW-1:0]      rep_q, rep_d;
    logic [GW-1:0]      gapcnt_q, gapcnt_d;
`ifdef LED_IDLE_HEARTBEAT_EN
    localparam int HW = $clog2(IDLE_TOGGLE + 1);
    localparam logic [HW-1:0] HB_LAST = HW'(IDLE_TOGGLE - 1);
    logic [HW-1:0]      hb_cnt_q, hb_cnt_d;
`endif

    logic               tick;
    logic [7:0]         pat_arr [N_REQ];
    logic               pick_found;
    logic [PW-1:0]      pick_idx;
    logic [SW-1:0]      pick_sum;
    logic [PW-1:0]      cand;

    // Split the flat pattern bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pat_arr[i] = pattern[8*i +: 8];
        end
    end

    // Free-running prescaler; tick marks the last cycle of each period.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Round-robin search from ptr upward; scanning downward lets the nearest hit win.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pick_sum = {1'b0, ptr_q} + SW'(k);
            if (pick_sum >= N_WRAP) begin
                pick_sum = pick_sum - N_WRAP;
            end
            cand = pick_sum[PW-1:0];
            if (req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Slot FSM: everything except the done pulse advances only on tick.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        led_d    = led_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        rep_d    = rep_q;
        gapcnt_d = gapcnt_q;
`ifdef LED_IDLE_HEARTBEAT_EN
        hb_cnt_d = hb_cnt_q;
`endif
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        owner_d  = pick_idx;
                        grant_d  = N_REQ'(1) << pick_idx;
                        ptr_d    = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
                        led_d    = pat_arr[pick_idx][7];
                        shreg_d  = pat_arr[pick_idx] << 1;
                        bitcnt_d = '0;
                        rep_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = S_PLAY;
                    end else begin
`ifdef LED_IDLE_HEARTBEAT_EN
                        if (hb_cnt_q == HB_LAST) begin
                            hb_cnt_d = '0;
                            led_d    = ~led_q;
                        end else begin
                            hb_cnt_d = hb_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                S_PLAY: begin
                    if (bitcnt_q != 3'd7) begin
                        led_d    = shreg_q[7];
                        shreg_d  = shreg_q << 1;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end else if (rep_q < REP_LAST && req[owner_q]) begin
                        // Pass boundary: the only point where a live pattern change is picked up.
                        led_d    = pat_arr[owner_q][7];
                        shreg_d  = pat_arr[owner_q] << 1;
                        bitcnt_d = '0;
                        rep_d    = rep_q + 1'b1;
                    end else begin
                        led_d    = 1'b0;
                        gapcnt_d = '0;
                        state_d  = S_GAP;
                    end
                end
                S_GAP: begin
                    led_d = 1'b0;
                    if (gapcnt_q == GAP_LAST) begin
                        grant_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`ifdef LED_IDLE_HEARTBEAT_EN
                        hb_cnt_d = '0;
`endif
                    end else begin
                        gapcnt_d = gapcnt_q + 1'b1;
                    end
                end
                default: begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    led_d   = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            led_q      <= 1'b0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            rep_q      <= '0;
            gapcnt_q   <= '0;
`ifdef LED_IDLE_HEARTBEAT_EN
            hb_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            led_q      <= led_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            rep_q      <= rep_d;
            gapcnt_q   <= gapcnt_d;
`ifdef LED_IDLE_HEARTBEAT_EN
            hb_cnt_q   <= hb_cnt_d;
`endif
        end
    end

    assign grant  = grant_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign WF_LED = led_q;

endmodule
